// File: rtl/seg_pkg.sv
// Shared types, glyph table and decode helper for the seven-segment readback path.
// Segment bit order: bit0=a ... bit6=g, active-high inside the design.
package seg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        COMMIT,
        HOLD
    } state_t;

    localparam seg_t SEG_BLANK = 7'h00;

    // Entry n is the lit pattern for hex digit n.
    localparam seg_t SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Returns {hit, nibble}; nibble is zero when nothing matches.
    function automatic logic [4:0] seg_decode(input seg_t seg);
        logic    hit;
        nibble_t nib;
        hit = 1'b0;
        nib = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_GLYPH[i]) begin
                hit = 1'b1;
                nib = nibble_t'(i);
            end
        end
        return {hit, nib};
    endfunction

endpackage

// File: rtl/seg_stable_cnt.sv
// Saturating run-length counter over the registered display sample.
// stable_o is high once the sample has held for STABLE_CYCLES compares in a row.
module seg_stable_cnt #(
    parameter int W             = 11,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] s_i,
    input  logic [W-1:0] p_i,
    output logic         changed_o,
    output logic         stable_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;

    assign changed_o = (s_i != p_i);

    always_comb begin
        cnt_d = cnt_q;
        if (changed_o) begin
            cnt_d = CW'(1);
        end else if (cnt_q != SAT) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stable_o = !changed_o && (cnt_q == SAT);

endmodule

// File: rtl/seg_scan_capture.sv
// Scanned seven-segment bus readback: debounce each strobed digit, decode, store.
// Define SEG_ACTIVE_LOW_EN for common-anode boards (segments/digit_en inverted at input).
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              segments,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    upd_pulse,
    output logic                    err_pulse,
    output logic [IDX_W-1:0]        upd_idx
);

    localparam int SW = 7 + NUM_DIGITS;

    logic [SW-1:0] in_w, s_q, p_q;

`ifdef SEG_ACTIVE_LOW_EN
    assign in_w = ~{digit_en, segments};
`else
    assign in_w = {digit_en, segments};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
            p_q <= '0;
        end else begin
            s_q <= in_w;
            p_q <= s_q;
        end
    end

    logic changed_w, stable_w;

    seg_stable_cnt #(
        .W            (SW),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_stable (
        .clk_i    (clk),
        .rst_i    (rst),
        .s_i      (s_q),
        .p_i      (p_q),
        .changed_o(changed_w),
        .stable_o (stable_w)
    );

    logic [NUM_DIGITS-1:0] en_w;
    seg_t                  seg_w;
    logic                  onehot_w;
    logic [IDX_W-1:0]      idx_w;
    logic [4:0]            dec_w;

    assign en_w     = s_q[SW-1:7];
    assign seg_w    = s_q[6:0];
    assign onehot_w = (en_w != '0) && ((en_w & (en_w - NUM_DIGITS'(1))) == '0);
    assign dec_w    = seg_decode(seg_w);

    always_comb begin
        idx_w = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (en_w[i]) idx_w = IDX_W'(i);
        end
    end

    state_t                           state_q, state_d;
    logic [NUM_DIGITS-1:0][3:0]       digits_q, digits_d;
    logic [NUM_DIGITS-1:0]            valid_q, valid_d;
    logic                             upd_q, upd_d, err_q, err_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;

    // The register-file write happens on the edge that enters COMMIT, so the
    // pulse is visible for exactly the COMMIT cycle.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        valid_d  = valid_q;
        upd_d    = 1'b0;
        err_d    = 1'b0;
        idx_d    = idx_q;
        unique case (state_q)
            IDLE: begin
                if (onehot_w) state_d = TRACK;
            end
            TRACK: begin
                if (!onehot_w) begin
                    state_d = IDLE;
                end else if (stable_w) begin
                    state_d = COMMIT;
                    idx_d   = idx_w;
                    if (dec_w[4]) begin
                        digits_d[idx_w] = dec_w[3:0];
                        valid_d[idx_w]  = 1'b1;
                        upd_d           = 1'b1;
                    end else if (seg_w == SEG_BLANK) begin
                        valid_d[idx_w]  = 1'b0;
                        upd_d           = 1'b1;
                    end else begin
                        err_d           = 1'b1;
                    end
                end
            end
            // A change already visible during COMMIT must not be lost on the way to HOLD.
            COMMIT, HOLD: begin
                if (changed_w) begin
                    state_d = onehot_w ? TRACK : IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            digits_q <= '0;
            valid_q  <= '0;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign upd_pulse   = upd_q;
    assign err_pulse   = err_q;
    assign upd_idx     = idx_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: directed plan steps plus random scan traffic
// against a run-length reference model. Honours SEG_ACTIVE_LOW_EN by inverting the drive.
module tb_seg_scan_capture;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [6:0]     segIn;
    logic [N-1:0]   enIn;
    logic [6:0]     segments;
    logic [N-1:0]   digit_en;
    logic [4*N-1:0] digits;
    logic [N-1:0]   digit_valid;
    logic           upd_pulse, err_pulse;
    logic [IW-1:0]  upd_idx;

`ifdef SEG_ACTIVE_LOW_EN
    assign segments = ~segIn;
    assign digit_en = ~enIn;
`else
    assign segments = segIn;
    assign digit_en = enIn;
`endif

    always #5 clk = ~clk;

    seg_scan_capture #(
        .NUM_DIGITS   (N),
        .STABLE_CYCLES(S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .segments   (segments),
        .digit_en   (digit_en),
        .digits     (digits),
        .digit_valid(digit_valid),
        .upd_pulse  (upd_pulse),
        .err_pulse  (err_pulse),
        .upd_idx    (upd_idx)
    );

    logic [6:0] glyphTab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference model: a one-hot bus value captured for S+1 consecutive edges
    // is committed on the following edge, once per run.
    logic [4*N-1:0] mDigits;
    logic [N-1:0]   mValid;
    logic           mUpd, mErr;
    logic [IW-1:0]  mIdx;
    logic [N+6:0]   mCap;
    int             mRun;

    always @(posedge clk) begin
        if (rst) begin
            mDigits = '0;
            mValid  = '0;
            mUpd    = 1'b0;
            mErr    = 1'b0;
            mIdx    = '0;
            mCap    = '0;
            mRun    = 1;
        end else begin
            mUpd = 1'b0;
            mErr = 1'b0;
            if (mRun == S + 1 && $countones(mCap[N+6:7]) == 1) begin
                int   pos;
                int   nib;
                logic hit;
                pos = 0;
                for (int i = 0; i < N; i++) if (mCap[7+i]) pos = i;
                hit = 1'b0;
                nib = 0;
                for (int t = 0; t < 16; t++) if (glyphTab[t] == mCap[6:0]) begin hit = 1'b1; nib = t; end
                mIdx = IW'(pos);
                if (hit) begin
                    mDigits[pos*4 +: 4] = 4'(nib);
                    mValid[pos] = 1'b1;
                    mUpd = 1'b1;
                end else if (mCap[6:0] == 7'h00) begin
                    mValid[pos] = 1'b0;
                    mUpd = 1'b1;
                end else begin
                    mErr = 1'b1;
                end
            end
            if ({enIn, segIn} == mCap) begin
                if (mRun < 1000) mRun++;
            end else begin
                mCap = {enIn, segIn};
                mRun = 1;
            end
        end
    end

    int asserts = 0;
    int fails   = 0;
    int updSeen = 0;
    int errSeen = 0;

    task automatic checkOutput(input string tag);
        asserts++;
        assert (digits === mDigits) else begin
            fails++; $error("[TB] FAIL %s digits: got %h expected %h", tag, digits, mDigits);
        end
        asserts++;
        assert (digit_valid === mValid) else begin
            fails++; $error("[TB] FAIL %s digit_valid: got %b expected %b", tag, digit_valid, mValid);
        end
        asserts++;
        assert (upd_pulse === mUpd) else begin
            fails++; $error("[TB] FAIL %s upd_pulse: got %b expected %b", tag, upd_pulse, mUpd);
        end
        asserts++;
        assert (err_pulse === mErr) else begin
            fails++; $error("[TB] FAIL %s err_pulse: got %b expected %b", tag, err_pulse, mErr);
        end
        asserts++;
        assert (upd_idx === mIdx) else begin
            fails++; $error("[TB] FAIL %s upd_idx: got %0d expected %0d", tag, upd_idx, mIdx);
        end
        if (upd_pulse === 1'b1) updSeen++;
        if (err_pulse === 1'b1) errSeen++;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        asserts++;
        assert (got === exp) else begin
            fails++; $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] seg, input logic [N-1:0] en, input int cycles, input string tag);
        repeat (cycles) begin
            segIn = seg;
            enIn  = en;
            @(posedge clk);
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    task automatic applyReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("reset");
        end
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        segIn = 7'h7F;
        enIn  = 4'b0001;
        @(negedge clk);

        applyReset(3);
        checkVal("reset digits", 32'(digits), 32'h0);
        checkVal("reset valid", 32'(digit_valid), 32'h0);
        checkVal("reset pulses", {30'b0, upd_pulse, err_pulse}, 32'h0);

        applyStimulus(7'h7F, 4'b0001, 5, "first window");
        checkVal("no commit before E5", 32'(upd_pulse), 32'h0);
        applyStimulus(7'h7F, 4'b0001, 1, "first commit");
        checkVal("E5 upd_pulse", 32'(upd_pulse), 32'h1);
        checkVal("E5 digit0", 32'(digits[3:0]), 32'h8);
        checkVal("E5 valid", 32'(digit_valid), 32'h1);
        checkVal("E5 upd_idx", 32'(upd_idx), 32'h0);

        updSeen = 0;
        for (int d = 0; d < N; d++) applyStimulus(glyphTab[d+1], N'(1) << d, 8, "scan");
        checkVal("scan digits", 32'(digits), 32'h4321);
        checkVal("scan valid", 32'(digit_valid), 32'hF);
        checkVal("scan upd count", 32'(updSeen), 32'd4);

        applyStimulus(7'h5B, 4'b0100, 6, "glitch pre");
        applyStimulus(7'h71, 4'b0100, 3, "glitch");
        checkVal("glitch digit2", 32'(digits[11:8]), 32'h2);
        applyStimulus(7'h5B, 4'b0100, 8, "glitch post");
        checkVal("glitch digit2 after", 32'(digits[11:8]), 32'h2);

        errSeen = 0;
        applyStimulus(7'h01, 4'b0010, 6, "bad pattern");
        checkVal("bad err_pulse", 32'(err_pulse), 32'h1);
        checkVal("bad upd_pulse", 32'(upd_pulse), 32'h0);
        checkVal("bad upd_idx", 32'(upd_idx), 32'h1);
        checkVal("bad valid1", 32'(digit_valid[1]), 32'h1);
        applyStimulus(7'h01, 4'b0010, 4, "bad hold");
        checkVal("bad single err", 32'(errSeen), 32'd1);

        updSeen = 0;
        errSeen = 0;
        applyStimulus(7'h3F, 4'b0011, 10, "two strobes");
        applyStimulus(7'h3F, 4'b0000, 10, "no strobe");
        checkVal("non-onehot pulses", 32'(updSeen + errSeen), 32'd0);
        applyStimulus(7'h00, 4'b1000, 6, "blank");
        checkVal("blank upd_pulse", 32'(upd_pulse), 32'h1);
        checkVal("blank valid3", 32'(digit_valid[3]), 32'h0);
        checkVal("blank digit3 kept", 32'(digits[15:12]), 32'h4);

        applyStimulus(7'h6D, 4'b0001, 3, "track before reset");
        applyReset(1);
        checkVal("midreset digits", 32'(digits), 32'h0);
        checkVal("midreset valid", 32'(digit_valid), 32'h0);
        updSeen = 0;
        applyStimulus(7'h6D, 4'b0001, 5, "after midreset");
        checkVal("midreset no pulse", 32'(updSeen), 32'd0);
        applyStimulus(7'h6D, 4'b0001, 1, "midreset recommit");
        checkVal("midreset digit0", 32'(digits[3:0]), 32'h5);

        for (int k = 0; k < 300; k++) begin
            logic [6:0]   rs;
            logic [N-1:0] re;
            int           sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       rs = glyphTab[$urandom_range(0, 15)];
            else if (sel == 6) rs = 7'h00;
            else               rs = 7'($urandom);
            sel = int'($urandom_range(0, 8));
            if (sel < 7)       re = N'(1) << $urandom_range(0, N - 1);
            else if (sel == 7) re = '0;
            else               re = N'($urandom);
            if ($urandom_range(0, 49) == 0) applyReset(1);
            applyStimulus(rs, re, int'($urandom_range(1, 8)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder.
- Monitors a multiplexed (scanned) seven-segment display bus: segment lines plus one-hot digit strobes.
- Waits until each strobed pattern is stable, decodes it back to a 4-bit hex nibble, and stores it in a per-digit register file.
- Used as a loopback checker and display-readback block between the display driver and the board pins.

Parameters:
- NUM_DIGITS, 4, number of scanned digits (≥1).
- STABLE_CYCLES, 4, consecutive cycles a sample must hold before commit (≥1).
- IDX_W, $clog2(NUM_DIGITS) (min 1), width of digit index (derived, localparam).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- segments  input  7  segment lines; bit0=a … bit6=g; active-high.
- digit_en  input  NUM_DIGITS  digit strobes; one-hot when a digit is driven; active-high.
- digits  output  4*NUM_DIGITS  decoded nibbles; digit i occupies bits [4i+3:4i].
- digit_valid  output  NUM_DIGITS  1 = digit i holds a decoded nibble.
- upd_pulse  output  1  one-cycle pulse: a digit was committed (decoded or blank).
- err_pulse  output  1  one-cycle pulse: a stable pattern matched no hex glyph.
- upd_idx  output  IDX_W  index of digit for the current upd_pulse/err_pulse.

Interface (already decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset values: digits=0, digit_valid=0, upd_pulse=0, err_pulse=0, upd_idx=0, FSM=IDLE, counter=0, input register=0.
- rst asserted mid-operation clears all stored digits and valid bits on that edge. Capture restarts from IDLE.
- Input stage: segments and digit_en are registered once into s_q. All logic operates on s_q and on its previous value p_q.
- Stability counter: cnt width $clog2(STABLE_CYCLES+1).
  - cnt <= 1 when s_q != p_q.
  - cnt increments while s_q == p_q, saturating at STABLE_CYCLES.
- FSM:
  - IDLE: digit_en part of s_q not one-hot (zero or ≥2 bits) → stay. One-hot → TRACK.
  - TRACK: s_q not one-hot → IDLE. cnt reaches STABLE_CYCLES with s_q unchanged → COMMIT.
  - COMMIT (one cycle): write the selected digit and raise exactly one pulse, then → HOLD.
  - HOLD: s_q != p_q → TRACK if one-hot, else IDLE. Each stable strobe window therefore commits once only.
- Commit timing: with inputs applied before edge E0 and then held, the registered outputs change at edge E(STABLE_CYCLES+1). The pulse lasts exactly one cycle.
- Glyph decode (7-bit pattern → nibble):
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7
  - 0x7F→8, 0x6F→9, 0x77→A, 0x7C→b, 0x39→C, 0x5E→d, 0x79→E, 0x71→F
- Commit outcomes for digit i (i = one-hot position):
  - Match: digits[i] <= nibble, digit_valid[i] <= 1, upd_pulse=1.
  - Blank pattern 0x00: digits[i] unchanged, digit_valid[i] <= 0, upd_pulse=1.
  - Any other pattern: digits[i] and digit_valid[i] unchanged, err_pulse=1.
- upd_pulse and err_pulse are never high together. upd_idx = i during either pulse and holds its value otherwise.
- Glitches shorter than STABLE_CYCLES never commit.
- Other digits' registers are never touched by a commit.

Optional Feature:
- Macro: SEG_ACTIVE_LOW_EN.
- Defined: segments and digit_en are inverted before the input register, for common-anode boards where 0 = lit/selected. All internal behaviour is identical.
- Undefined: inputs are used as-is (active-high).

Decomposition:
- Package seg_pkg:
  - typedef seg_t (logic [6:0]) and nibble_t (logic [3:0]).
  - Constants SEG_BLANK=7'h00 and the 16-entry glyph table.
  - Function seg_decode(seg_t) returning {hit, nibble_t}.
  - State enum {IDLE, TRACK, COMMIT, HOLD}.
- One sub-module, seg_stable_cnt: compares s_q/p_q and produces the saturating counter and a stable flag.
- FSM and register file stay in seg_scan_capture.

Test Plan:
- Reset: drive segments=0x7F, digit_en=4'b0001, hold rst 3 cycles → digits=0, digit_valid=0, no pulse; after release, commit at E5 (STABLE_CYCLES=4) → digits[3:0]=8, digit_valid=4'b0001, upd_idx=0.
- Scan: cycle digits 0..3 with 0x06, 0x5B, 0x4F, 0x66, each held 8 cycles → digits=16'h4321, digit_valid=4'hF, exactly 4 upd_pulses.
- Glitch: on digit 2, insert 0x71 for 3 cycles inside a stable 0x5B window → no commit of F; digits[11:8] unchanged.
- Bad pattern: segments=0x01 on digit 1, held 6 cycles → single err_pulse with upd_idx=1, digit_valid[1] unchanged.
- Non-one-hot: digit_en=4'b0011 or 0000 held 10 cycles → no pulses; blank 0x00 on digit 3 → digit_valid[3]=0, upd_pulse=1.
- Mid-op reset: assert rst one cycle during TRACK → outputs cleared, no pulse for the interrupted window; rebuild with SEG_ACTIVE_LOW_EN and inverted stimulus → identical results.
